fp_alu_seq: RTL



---
 rtl/fp_alu_pkg.sv | 22 ++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_alu_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_alu_pkg.sv
// Shared opcodes, FSM state encoding and exponent bias helper for the sequential FP ALU.
package fp_alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ADD,
    S_MUL,
    S_NORM,
    S_DONE
  } state_t;

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH and is handled by the caller.
module fp_lzc #(
  parameter int unsigned WIDTH = 25,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] val,
  output logic [CNT_W-1:0] cnt
);

  // Scan upward so the highest set bit writes last.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (val[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_alu_seq.sv
// Multi-cycle add/sub/mul floating-point ALU with valid/ready handshakes, one op in flight.
module fp_alu_seq
  import fp_alu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   para1,
  input  logic [EXP_W+MAN_W:0]   para2,
  input  logic [1:0]             ALU_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic                   zero,
  output logic                   under_overflow
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned MW    = MAN_W + 1;
  localparam int unsigned SW    = MAN_W + 2;
  localparam int unsigned PW    = 2 * MW;
  localparam int unsigned XW    = EXP_W + 2;
  localparam int unsigned CW    = $clog2(SW);
  localparam int unsigned NW    = $clog2(MW);
  localparam int unsigned SHMAX = MAN_W + 2;

  localparam logic signed [XW-1:0] BIAS_X = XW'(bias(EXP_W));
  localparam logic signed [XW-1:0] EMAX_X = XW'((32'd1 << EXP_W) - 32'd1);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t state, state_nxt;

  logic [1:0]             op_q;
  logic [W-1:0]           p1_q, p2_q;
  logic [MW-1:0]          ma_q, mb_q, mplier_q;
  logic                   sa_q, sb_q, res_sign_q;
  logic signed [XW-1:0]   res_exp_q;
  logic [SW-1:0]          sum_q;
  logic [PW-1:0]          prod_q, mcand_q, prod_nxt;
  logic [NW-1:0]          cnt_q;

  // Operand unpacking of the captured words
  logic                   s1, s2, s2e, z1, z2, nan_c, swap;
  logic [EXP_W-1:0]       e1, e2, diff;
  logic [MW-1:0]          m1, m2, small_m, aligned;

  assign s1      = p1_q[W-1];
  assign s2      = p2_q[W-1];
  assign e1      = p1_q[W-2 -: EXP_W];
  assign e2      = p2_q[W-2 -: EXP_W];
  assign m1      = {1'b1, p1_q[MAN_W-1:0]};
  assign m2      = {1'b1, p2_q[MAN_W-1:0]};
  assign s2e     = s2 ^ (op_q == OP_SUB);
  assign z1      = (e1 == '0);
  assign z2      = (e2 == '0);
  assign nan_c   = (&e1) | (&e2);
  assign swap    = (e2 > e1) || ((e2 == e1) && (m2 > m1));
  assign diff    = swap ? (e2 - e1) : (e1 - e2);
  assign small_m = swap ? m1 : m2;
  assign aligned = (32'(diff) > SHMAX) ? '0 : (small_m >> diff);

  assign in_ready = (state == S_IDLE);
  assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Special-case result resolved in PREP
  logic           special;
  logic [W-1:0]   spec_out;
  logic           spec_zero, spec_uo;

  always_comb begin
    special   = 1'b1;
    spec_out  = '0;
    spec_zero = 1'b0;
    spec_uo   = 1'b0;
    if (nan_c) begin
      spec_out = QNAN;
      spec_uo  = 1'b1;
    end else if (op_q == OP_RSVD) begin
      spec_zero = 1'b1;
    end else if (z1 || z2) begin
      if (op_q == OP_MUL) begin
        spec_zero = 1'b1;
      end else if (z1) begin
        spec_out  = z2 ? {s2e, {(W-1){1'b0}}} : {s2e, p2_q[W-2:0]};
        spec_zero = z2;
      end else begin
        spec_out = p1_q;
      end
    end else begin
      special = 1'b0;
    end
  end

  // Normalisation: carry-out shifts right, otherwise shift out leading zeros
  logic [CW-1:0]          lz;
  logic signed [XW-1:0]   lz_x, exp_adj;
  logic [MAN_W-1:0]       man_norm;
  logic [W-1:0]           norm_out;
  logic                   norm_zero, norm_uo;

  fp_lzc #(.WIDTH(SW)) u_lzc (
    .val (sum_q),
    .cnt (lz)
  );

  assign lz_x = XW'(lz);

  always_comb begin
    if (sum_q[SW-1]) begin
      man_norm = sum_q[MAN_W:1];
      exp_adj  = res_exp_q + ONE_X;
    end else begin
      man_norm = MAN_W'(sum_q << (lz - CW'(1)));
      exp_adj  = res_exp_q - lz_x + ONE_X;
    end
  end

  always_comb begin
    norm_out  = {res_sign_q, exp_adj[EXP_W-1:0], man_norm};
    norm_zero = 1'b0;
    norm_uo   = 1'b0;
    if (sum_q == '0) begin
      norm_out  = '0;
      norm_zero = 1'b1;
    end else if (exp_adj >= EMAX_X) begin
      norm_out = {res_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_uo  = 1'b1;
    end else if (exp_adj <= ZERO_X) begin
      norm_out  = {res_sign_q, {(W-1){1'b0}}};
      norm_zero = 1'b1;
      norm_uo   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_PREP;
      S_PREP: state_nxt = special ? S_DONE : ((op_q == OP_MUL) ? S_MUL : S_ADD);
      S_ADD:  state_nxt = S_NORM;
      S_MUL:  if (cnt_q == NW'(MAN_W)) state_nxt = S_NORM;
      S_NORM: state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q           <= '0;
      p1_q           <= '0;
      p2_q           <= '0;
      ma_q           <= '0;
      mb_q           <= '0;
      sa_q           <= 1'b0;
      sb_q           <= 1'b0;
      res_sign_q     <= 1'b0;
      res_exp_q      <= '0;
      sum_q          <= '0;
      prod_q         <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      cnt_q          <= '0;
      out            <= '0;
      zero           <= 1'b0;
      under_overflow <= 1'b0;
      out_valid      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q <= ALU_op;
            p1_q <= para1;
            p2_q <= para2;
          end
        end
        S_PREP: begin
          if (special) begin
            out            <= spec_out;
            zero           <= spec_zero;
            under_overflow <= spec_uo;
            out_valid      <= 1'b1;
          end else if (op_q == OP_MUL) begin
            mcand_q    <= PW'(m1);
            mplier_q   <= m2;
            prod_q     <= '0;
            cnt_q      <= '0;
            res_sign_q <= s1 ^ s2;
            res_exp_q  <= XW'(e1) + XW'(e2) - BIAS_X;
          end else begin
            ma_q      <= swap ? m2 : m1;
            mb_q      <= aligned;
            sa_q      <= swap ? s2e : s1;
            sb_q      <= swap ? s1 : s2e;
            res_exp_q <= XW'(swap ? e2 : e1);
          end
        end
        S_ADD: begin
          sum_q      <= (sa_q == sb_q) ? (SW'(ma_q) + SW'(mb_q)) : (SW'(ma_q) - SW'(mb_q));
          res_sign_q <= sa_q;
        end
        S_MUL: begin
          prod_q   <= prod_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + NW'(1);
          if (cnt_q == NW'(MAN_W)) sum_q <= prod_nxt[PW-1 -: SW];
        end
        S_NORM: begin
          out            <= norm_out;
          zero           <= norm_zero;
          under_overflow <= norm_uo;
          out_valid      <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
